// File: rtl/factor_pkg.sv
// Shared constants, key codes and entry-state encoding for the factorization game answer path.
package factor_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_W    = 4;

    localparam logic [DIGIT_W-1:0] KEY_BKSP  = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hE;
    localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D1   = 2'd1,
        D2   = 2'd2,
        D3   = 2'd3
    } entry_state_t;

    function automatic logic isDigit(input logic [DIGIT_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/answer_entry_if.sv
// Keypad-side inputs and answer-checker-side outputs of the player-1 answer entry stage.
interface answer_entry_if;
    import factor_pkg::*;

    logic               KEY_PRESS;
    logic [DIGIT_W-1:0] KEY_CODE;
    logic               NEW_Q;
    logic [DIGIT_W-1:0] ANSWER_1;
    logic [DIGIT_W-1:0] ANSWER_2;
    logic [DIGIT_W-1:0] ANSWER_3;
    logic               ANSWER_VALID;
    logic [1:0]         DIGIT_CNT;
    logic               TIMEOUT;

    modport master (
        output KEY_PRESS, KEY_CODE, NEW_Q,
        input  ANSWER_1, ANSWER_2, ANSWER_3, ANSWER_VALID, DIGIT_CNT, TIMEOUT
    );

    modport slave (
        input  KEY_PRESS, KEY_CODE, NEW_Q,
        output ANSWER_1, ANSWER_2, ANSWER_3, ANSWER_VALID, DIGIT_CNT, TIMEOUT
    );

endinterface

// File: rtl/answer_entry_key_debounce.sv
// Synchronises the raw keypad strobe/code and emits one registered event per debounced press.
module key_debounce
    import factor_pkg::*;
#(
    parameter logic [19:0] DEB_CYC = 20'd500000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_keyPress,
    input  logic [DIGIT_W-1:0] i_keyCode,
    output logic               o_keyEvt,
    output logic [DIGIT_W-1:0] o_keyCode
);

    logic               r_pressSync1;
    logic               r_pressSync2;
    logic [DIGIT_W-1:0] r_codeSync1;
    logic [DIGIT_W-1:0] r_codeSync2;
    logic [19:0]        r_cnt;
    logic               r_armed;
    logic               r_evt;
    logic [DIGIT_W-1:0] r_code;

    // Reset leaves the debouncer disarmed so a key held through reset must be released first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pressSync1 <= 1'b0;
            r_pressSync2 <= 1'b0;
            r_codeSync1  <= '0;
            r_codeSync2  <= '0;
            r_cnt        <= '0;
            r_armed      <= 1'b0;
            r_evt        <= 1'b0;
            r_code       <= '0;
        end else begin
            r_pressSync1 <= i_keyPress;
            r_pressSync2 <= r_pressSync1;
            r_codeSync1  <= i_keyCode;
            r_codeSync2  <= r_codeSync1;
            r_evt        <= 1'b0;
            if (r_pressSync2 == r_armed) begin
                if (r_cnt >= DEB_CYC - 20'd1) begin
                    r_cnt   <= '0;
                    r_armed <= ~r_armed;
                    if (r_armed) begin
                        r_evt  <= 1'b1;
                        r_code <= r_codeSync2;
                    end
                end else begin
                    r_cnt <= r_cnt + 20'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_keyEvt  = r_evt;
    assign o_keyCode = r_code;

endmodule

// File: rtl/answer_entry.sv
// Player-1 answer entry: assembles three factor digits from debounced keys and commits them on ENTER.
module answer_entry
    import factor_pkg::*;
#(
    parameter logic [19:0] DEB_CYC     = 20'd500000,
    parameter logic [31:0] TIMEOUT_CYC = 32'd0
) (
    input  logic         CLK,
    input  logic         RST,
    answer_entry_if.slave bus
);

    logic               w_keyEvt;
    logic [DIGIT_W-1:0] w_keyCode;

    entry_state_t       r_state;
    logic [DIGIT_W-1:0] r_buf1;
    logic [DIGIT_W-1:0] r_buf2;
    logic [DIGIT_W-1:0] r_buf3;
    logic [DIGIT_W-1:0] r_ans1;
    logic [DIGIT_W-1:0] r_ans2;
    logic [DIGIT_W-1:0] r_ans3;
    logic               r_ansValid;
    logic               r_timeout;
    logic [31:0]        r_toCnt;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_keyDebounce (
        .CLK        (CLK),
        .RST        (RST),
        .i_keyPress (bus.KEY_PRESS),
        .i_keyCode  (bus.KEY_CODE),
        .o_keyEvt   (w_keyEvt),
        .o_keyCode  (w_keyCode)
    );

    // NEW_Q outranks a coincident key event; the idle timer only runs on a partial entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_buf1     <= '0;
            r_buf2     <= '0;
            r_buf3     <= '0;
            r_ans1     <= '0;
            r_ans2     <= '0;
            r_ans3     <= '0;
            r_ansValid <= 1'b0;
            r_timeout  <= 1'b0;
            r_toCnt    <= '0;
        end else begin
            r_ansValid <= 1'b0;
            r_timeout  <= 1'b0;
            if (bus.NEW_Q) begin
                r_state <= IDLE;
                r_buf1  <= '0;
                r_buf2  <= '0;
                r_buf3  <= '0;
                r_ans1  <= '0;
                r_ans2  <= '0;
                r_ans3  <= '0;
                r_toCnt <= '0;
            end else if (w_keyEvt) begin
                r_toCnt <= '0;
                if (isDigit(w_keyCode)) begin
                    case (r_state)
                        IDLE:    begin r_buf1 <= w_keyCode; r_state <= D1; end
                        D1:      begin r_buf2 <= w_keyCode; r_state <= D2; end
                        D2:      begin r_buf3 <= w_keyCode; r_state <= D3; end
                        default: ;
                    endcase
                end else if (w_keyCode == KEY_BKSP) begin
                    case (r_state)
                        D3:      begin r_buf3 <= '0; r_state <= D2; end
                        D2:      begin r_buf2 <= '0; r_state <= D1; end
                        D1:      begin r_buf1 <= '0; r_state <= IDLE; end
                        default: ;
                    endcase
                end else if (w_keyCode == KEY_ENTER && r_state == D3) begin
                    r_ans1     <= r_buf1;
                    r_ans2     <= r_buf2;
                    r_ans3     <= r_buf3;
                    r_ansValid <= 1'b1;
                    r_buf1     <= '0;
                    r_buf2     <= '0;
                    r_buf3     <= '0;
                    r_state    <= IDLE;
                end else if (w_keyCode == KEY_CLEAR) begin
                    r_buf1  <= '0;
                    r_buf2  <= '0;
                    r_buf3  <= '0;
                    r_state <= IDLE;
                end
            end else if (TIMEOUT_CYC != 32'd0 && r_state != IDLE) begin
                if (r_toCnt >= TIMEOUT_CYC - 32'd1) begin
                    r_toCnt   <= '0;
                    r_timeout <= 1'b1;
                    r_buf1    <= '0;
                    r_buf2    <= '0;
                    r_buf3    <= '0;
                    r_state   <= IDLE;
                end else begin
                    r_toCnt <= r_toCnt + 32'd1;
                end
            end else begin
                r_toCnt <= '0;
            end
        end
    end

    assign bus.ANSWER_1     = r_ans1;
    assign bus.ANSWER_2     = r_ans2;
    assign bus.ANSWER_3     = r_ans3;
    assign bus.ANSWER_VALID = r_ansValid;
    assign bus.TIMEOUT      = r_timeout;
    assign bus.DIGIT_CNT    = r_state;

endmodule

// File: tb/tb_answer_entry.sv
// Directed-vector bench for answer_entry with a scoreboard for ANSWER_VALID / TIMEOUT events.
module tb_answer_entry;

    logic CLK;
    logic RST;
    int   vecCount;
    int   missCount;

    typedef struct {
        logic       isTimeout;
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] a3;
    } expEvt_t;

    expEvt_t expQ[$];

    answer_entry_if bus();

    answer_entry #(
        .DEB_CYC     (20'd4),
        .TIMEOUT_CYC (32'd50)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Pops one expected event for every ANSWER_VALID or TIMEOUT pulse the DUT shows.
    initial begin
        expEvt_t e;
        forever begin
            @(negedge CLK);
            if (!RST && (bus.ANSWER_VALID || bus.TIMEOUT)) begin
                vecCount++;
                if (expQ.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL unexpected_event: got valid=%0b timeout=%0b ans=%h/%h/%h, want no event",
                             bus.ANSWER_VALID, bus.TIMEOUT, bus.ANSWER_1, bus.ANSWER_2, bus.ANSWER_3);
                end else begin
                    e = expQ.pop_front();
                    if ({bus.ANSWER_VALID, bus.TIMEOUT, bus.ANSWER_1, bus.ANSWER_2, bus.ANSWER_3} !==
                        {~e.isTimeout, e.isTimeout, e.a1, e.a2, e.a3}) begin
                        missCount++;
                        $display("[TB] FAIL event: got valid=%0b timeout=%0b ans=%h/%h/%h, want valid=%0b timeout=%0b ans=%h/%h/%h",
                                 bus.ANSWER_VALID, bus.TIMEOUT, bus.ANSWER_1, bus.ANSWER_2, bus.ANSWER_3,
                                 ~e.isTimeout, e.isTimeout, e.a1, e.a2, e.a3);
                    end
                end
            end
        end
    end

    task automatic expectEvent(input logic isTimeout, input logic [3:0] a1, input logic [3:0] a2,
                               input logic [3:0] a3);
        expEvt_t e;
        e.isTimeout = isTimeout;
        e.a1 = a1;
        e.a2 = a2;
        e.a3 = a3;
        expQ.push_back(e);
    endtask

    // One clean key press: held 10 cycles, released 10 cycles so the debouncer re-arms.
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge CLK);
        bus.KEY_CODE  = code;
        bus.KEY_PRESS = 1'b1;
        repeat (10) @(negedge CLK);
        bus.KEY_PRESS = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic applyBounce(input logic [3:0] code);
        @(negedge CLK);
        bus.KEY_CODE = code;
        for (int i = 0; i < 6; i++) begin
            bus.KEY_PRESS = ~bus.KEY_PRESS;
            @(negedge CLK);
        end
        bus.KEY_PRESS = 1'b1;
        repeat (10) @(negedge CLK);
        bus.KEY_PRESS = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] cnt, input logic [3:0] a1,
                               input logic [3:0] a2, input logic [3:0] a3);
        vecCount++;
        if ({bus.DIGIT_CNT, bus.ANSWER_1, bus.ANSWER_2, bus.ANSWER_3} !== {cnt, a1, a2, a3}) begin
            missCount++;
            $display("[TB] FAIL %s: got cnt=%0d ans=%h/%h/%h, want cnt=%0d ans=%h/%h/%h", name,
                     bus.DIGIT_CNT, bus.ANSWER_1, bus.ANSWER_2, bus.ANSWER_3, cnt, a1, a2, a3);
        end
    endtask

    task automatic checkPulses(input string name);
        vecCount++;
        if ({bus.ANSWER_VALID, bus.TIMEOUT} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL %s: got valid=%0b timeout=%0b, want 0/0", name, bus.ANSWER_VALID, bus.TIMEOUT);
        end
    endtask

    task automatic checkQueue(input string name);
        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d events still pending, want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        vecCount       = 0;
        missCount      = 0;
        RST            = 1'b1;
        bus.KEY_PRESS  = 1'b0;
        bus.KEY_CODE   = 4'h0;
        bus.NEW_Q      = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_state", 2'd0, 4'h0, 4'h0, 4'h0);
        checkPulses("reset_pulses");
        RST = 1'b0;
        repeat (10) @(negedge CLK);

        $display("[TB] basic entry and commit");
        applyStimulus(4'h3);
        checkOutput("t1_cnt1", 2'd1, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'h5);
        checkOutput("t1_cnt2", 2'd2, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'h7);
        checkOutput("t1_cnt3", 2'd3, 4'h0, 4'h0, 4'h0);
        expectEvent(1'b0, 4'h3, 4'h5, 4'h7);
        applyStimulus(4'hE);
        checkOutput("t1_commit", 2'd0, 4'h3, 4'h5, 4'h7);
        checkQueue("t1_events");

        $display("[TB] bouncy press");
        applyBounce(4'h2);
        checkOutput("t2_bounce", 2'd1, 4'h3, 4'h5, 4'h7);
        applyStimulus(4'hF);
        checkOutput("t2_clear", 2'd0, 4'h3, 4'h5, 4'h7);

        $display("[TB] backspace and early enter");
        applyStimulus(4'h4);
        applyStimulus(4'h6);
        applyStimulus(4'hA);
        checkOutput("t3_bksp", 2'd1, 4'h3, 4'h5, 4'h7);
        applyStimulus(4'h8);
        applyStimulus(4'h9);
        expectEvent(1'b0, 4'h4, 4'h8, 4'h9);
        applyStimulus(4'hE);
        checkOutput("t3_commit", 2'd0, 4'h4, 4'h8, 4'h9);
        applyStimulus(4'h1);
        applyStimulus(4'hE);
        checkOutput("t3_early_enter", 2'd1, 4'h4, 4'h8, 4'h9);
        applyStimulus(4'hC);
        checkOutput("t3_ignored_code", 2'd1, 4'h4, 4'h8, 4'h9);
        applyStimulus(4'hF);
        checkQueue("t3_events");

        $display("[TB] new question");
        applyStimulus(4'h3);
        applyStimulus(4'h5);
        applyStimulus(4'h7);
        expectEvent(1'b0, 4'h3, 4'h5, 4'h7);
        applyStimulus(4'hE);
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        checkOutput("t4_partial", 2'd2, 4'h3, 4'h5, 4'h7);
        bus.NEW_Q = 1'b1;
        @(negedge CLK);
        bus.NEW_Q = 1'b0;
        checkOutput("t4_new_q", 2'd0, 4'h0, 4'h0, 4'h0);
        applyStimulus(4'h2);
        applyStimulus(4'h3);
        applyStimulus(4'h4);
        expectEvent(1'b0, 4'h2, 4'h3, 4'h4);
        applyStimulus(4'hE);
        checkOutput("t4_recommit", 2'd0, 4'h2, 4'h3, 4'h4);
        checkQueue("t4_events");

        $display("[TB] timeout and clear");
        applyStimulus(4'h1);
        applyStimulus(4'h2);
        expectEvent(1'b1, 4'h2, 4'h3, 4'h4);
        repeat (60) @(negedge CLK);
        checkOutput("t5_timeout", 2'd0, 4'h2, 4'h3, 4'h4);
        checkQueue("t5_timeout_event");
        applyStimulus(4'h5);
        applyStimulus(4'hF);
        checkOutput("t5_clear", 2'd0, 4'h2, 4'h3, 4'h4);
        checkQueue("t5_events");

        $display("[TB] reset with held key");
        applyStimulus(4'h1);
        bus.KEY_CODE  = 4'h7;
        bus.KEY_PRESS = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("t6_reset", 2'd0, 4'h0, 4'h0, 4'h0);
        checkPulses("t6_reset_pulses");
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        checkOutput("t6_held_ignored", 2'd0, 4'h0, 4'h0, 4'h0);
        bus.KEY_PRESS = 1'b0;
        repeat (10) @(negedge CLK);
        applyStimulus(4'h7);
        checkOutput("t6_repress", 2'd1, 4'h0, 4'h0, 4'h0);
        checkQueue("t6_events");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
